// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared definitions for the sequential carry-lookahead adder.
// Holds the FSM state encoding, the nibble width and the nibble-count helper.
`default_nettype none

package cla_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   function automatic int num_nibbles(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cla4_aug.sv
// cla4_aug: 4-bit carry-lookahead slice with group propagate/generate outputs.
`default_nettype none

module cla4_aug (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       pout,
   output logic       gout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c;
   assign pout = &p;
   assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder that streams one nibble per cycle through a shared cla4_aug.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf_o.
`default_nettype none

module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
`ifdef CLA_SEQ_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int N     = num_nibbles(WIDTH);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
`ifdef CLA_SEQ_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [IDX_W+1:0]   bit_base;
   logic [3:0]         slice_a;
   logic [3:0]         slice_b;
   logic [3:0]         slice_s;
   logic               slice_p;
   logic               slice_g;
   logic               carry_new;

   // Nibble select: the index picks which operand nibble feeds the shared slice.
   assign bit_base  = {idx_q, 2'b00};
   assign slice_a   = op_a_q[bit_base +: NIBBLE_W];
   assign slice_b   = op_b_q[bit_base +: NIBBLE_W];
   assign carry_new = slice_g | (slice_p & carry_q);

   cla4_aug u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .s    (slice_s),
      .pout (slice_p),
      .gout (slice_g)
   );

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               op_a_d  = a_i;
               op_b_d  = b_i;
               carry_d = cin_i;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_d[bit_base +: NIBBLE_W] = slice_s;
            carry_d = carry_new;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = carry_new;
`ifdef CLA_SEQ_OVF_EN
               // Slice MSB on the final nibble is the new sign bit of the sum.
               ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (slice_s[3] != op_a_q[WIDTH-1]);
`endif
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy_o = (state_q == ST_RUN);
   assign done_o = (state_q == ST_DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
`ifdef CLA_SEQ_OVF_EN
   assign ovf_o  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: table-driven check of cla_seq_adder at WIDTH=16 plus multi-cycle corner cases.
`default_nettype none

module tb_cla_seq_adder;

   localparam int W = 16;
   localparam int N = W / 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
`ifdef CLA_SEQ_OVF_EN
   logic          ovf;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs [9];

   cla_seq_adder #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .cin_i   (cin),
      .busy_o  (busy),
      .done_o  (done),
      .sum_o   (sum),
      .cout_o  (cout)
`ifdef CLA_SEQ_OVF_EN
      ,
      .ovf_o   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      @(negedge clk);
      start = 1'b1; a = v.a; b = v.b; cin = v.cin;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
      chk($sformatf("v%0d busy_e0", id), busy, 1);
      for (int k = 1; k < N; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("v%0d busy_run%0d", id, k), {busy, done}, 2'b10);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done", id), {busy, done}, 2'b01);
      chk($sformatf("v%0d sum", id), sum, v.exp_sum);
      chk($sformatf("v%0d cout", id), cout, v.exp_cout);
`ifdef CLA_SEQ_OVF_EN
      chk($sformatf("v%0d ovf", id), ovf, v.exp_ovf);
`endif
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done_pulse", id), {busy, done}, 2'b00);
      chk($sformatf("v%0d sum_hold", id), sum, v.exp_sum);
   endtask

   initial begin
      int dcnt;
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0007, 16'h0008, 1'b1, 16'h0010, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset busy/done", {busy, done}, 2'b00);
      chk("reset sum", sum, 0);
      chk("reset cout", cout, 0);
`ifdef CLA_SEQ_OVF_EN
      chk("reset ovf", ovf, 0);
`endif

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Start re-asserted mid-run with different operands must be ignored.
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("ign done", {busy, done}, 2'b01);
      chk("ign sum", sum, 16'h5555);
      chk("ign cout", cout, 0);
      dcnt = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
      end
      chk("ign extra_done", dcnt, 0);
      chk("ign sum_hold", sum, 16'h5555);

      // Reset in the middle of RUN aborts without a done pulse.
      @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort busy/done", {busy, done}, 2'b00);
      chk("abort sum", sum, 0);
      chk("abort cout", cout, 0);
      dcnt = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done || busy) dcnt++;
      end
      chk("abort no_activity", dcnt, 0);
      run_vec(vecs[7], 70);

      // Back-to-back: start held high, next operands presented in each DONE cycle.
      @(negedge clk);
      start = 1'b1; a = vecs[1].a; b = vecs[1].b; cin = vecs[1].cin;
      @(posedge clk);
      for (int j = 0; j < 3; j++) begin
         vec_t cur;
         cur = (j == 0) ? vecs[1] : (j == 1) ? vecs[2] : vecs[4];
         #1;
         a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
         repeat (N - 1) @(posedge clk);
         #1;
         chk($sformatf("b2b%0d pre", j), {busy, done}, 2'b10);
         @(posedge clk);
         #1;
         chk($sformatf("b2b%0d done", j), {busy, done}, 2'b01);
         chk($sformatf("b2b%0d sum", j), sum, cur.exp_sum);
         chk($sformatf("b2b%0d cout", j), cout, cur.exp_cout);
         if (j == 0) begin
            a = vecs[2].a; b = vecs[2].b; cin = vecs[2].cin;
         end else if (j == 1) begin
            a = vecs[4].a; b = vecs[4].b; cin = vecs[4].cin;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
      end
      #1;
      chk("b2b idle", {busy, done}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle WIDTH-bit adder controller that time-shares one `cla4_aug` 4-bit carry-lookahead slice across all nibbles of its operands. It latches operands on a `start`/`done` handshake and feeds nibble i to the slice in cycle i. The nibble carry is registered between cycles as `gout | (pout & carry)`. The block sits between the lab top level / register file and the CLA datapath, trading latency for area against a fully unrolled adder.

## Interface
- `WIDTH`, default 16: operand width in bits; must be a multiple of 4 and at least 8.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: request; sampled only in IDLE or DONE.
- `a` in WIDTH: operand A; sampled on the accepting edge only.
- `b` in WIDTH: operand B; sampled on the accepting edge only.
- `cin` in 1: carry-in; sampled on the accepting edge only.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; `sum` and `cout` are valid in that cycle.
- `sum` out WIDTH: result; holds until the next accepted start or reset.
- `cout` out 1: carry-out of the MSB nibble; held like `sum`.
- `ovf` out 1: signed overflow; present only with the macro (see Configuration).

## Operation
- N = WIDTH/4 nibbles; 2-bit FSM states: IDLE, RUN, DONE.
- Reset values:
  - state = IDLE.
  - `busy`, `done`, `cout`, `ovf` = 0.
  - `sum` = 0.
  - Operand registers and nibble index = 0.
  - Carry register = 0.
- IDLE or DONE with `start`=1:
  - latch `a`, `b` into operand regs.
  - carry register <= `cin`; index <= 0.
  - clear `sum`, `cout`, `ovf`; go to RUN.
- IDLE with `start`=0: stay.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle, with index i:
  - slice inputs: a = opA[4i+3:4i], b = opB[4i+3:4i], cin = carry register.
  - `sum[4i+3:4i]` <= slice `s`.
  - carry <= `gout | (pout & carry)`.
  - index <= i+1.
  - If i = N-1: `cout` <= the new carry and go to DONE.
- `start` during RUN is ignored; operands in flight are unaffected.
- Index counter is $clog2(N) bits and never wraps inside RUN; the exit is decoded on i = N-1.
- `rst` has priority over everything, including mid-RUN. A transaction aborted by reset produces no `done` pulse.
- Input changes on `a`, `b`, `cin` outside the accepting edge have no effect.

## Timing
- Accept edge E0. `busy`=1 from E0 through E(N).
- Nibble i result is registered at edge E(i+1).
- `done`=1 for exactly the cycle between E(N) and E(N+1).
- Latency start→done is N cycles (4 at WIDTH=16).
- Back-to-back operation: `start` held high in the DONE cycle is accepted at E(N+1), giving one result every N+1 cycles.
- `done` and `busy` are never high together.
- The slice path is combinational within one cycle. The critical path is operand mux → `cla4_aug` → carry register.

## Configuration
- `CLA_SEQ_OVF_EN` defined:
  - `ovf` port exists.
  - at E(N), `ovf` <= (opA[W-1] == opB[W-1]) && (new sum[W-1] != opA[W-1]).
  - `ovf` holds with `sum`.
- Not defined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- Shared package `cla_seq_pkg`:
  - FSM state typedef (IDLE/RUN/DONE).
  - `NIBBLE_W` = 4.
  - a function returning N from WIDTH.
- Exactly one sub-module instance: the existing `cla4_aug` (`s`, `pout`, `gout`, `a`, `b`, `cin`), unmodified.
- Nibble select is a mux in the controller; the carry register, FSM and index all live in `cla_seq_adder`.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → `busy` for 4 cycles, then `done` with sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all 4 nibbles). Also a=0x0007, b=0x0008, cin=1 → sum=0x0010, cout=0.
- With `CLA_SEQ_OVF_EN`: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1. a=0x8000, b=0xFFFF → sum=0x7FFF, cout=1, ovf=1.
- `start` pulsed again at cycle 2 of RUN with different operands → ignored; the first result is unchanged and only one `done` pulse occurs.
- `rst` asserted at cycle 2 of RUN → next cycle state IDLE with sum=0, busy=0, and no `done`. A fresh start then completes normally.
- `start` held high continuously with new operands presented in each DONE cycle → `done` every 5 cycles with the correct sums each time.
